// File: rtl/conv_fmap_streamer_if.sv
// Bundle between the convolution output array, the streamer and the downstream
// element consumer. The streamer attaches through the slave modport.
interface conv_fmap_streamer_if #(
    parameter int OUT_DEPTH  = 32,
    parameter int OUT_HEIGHT = 5,
    parameter int OUT_WIDTH  = 5,
    parameter int DATA_W     = 18
);
    localparam int CH_W  = (OUT_DEPTH  > 1) ? $clog2(OUT_DEPTH)  : 1;
    localparam int ROW_W = (OUT_HEIGHT > 1) ? $clog2(OUT_HEIGHT) : 1;
    localparam int COL_W = (OUT_WIDTH  > 1) ? $clog2(OUT_WIDTH)  : 1;

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // Once valid is high, valid and every payload bit hold until that edge;
    // ready may toggle freely and never gates valid combinationally.
    logic                     fm_valid;
    logic                     fm_ready;
    logic signed [DATA_W-1:0] fm_data [0:OUT_DEPTH-1][0:OUT_HEIGHT-1][0:OUT_WIDTH-1];

    logic                     m_valid;
    logic                     m_ready;
    logic signed [DATA_W-1:0] m_data;
    logic [CH_W-1:0]          m_ch;
    logic [ROW_W-1:0]         m_row;
    logic [COL_W-1:0]         m_col;
    logic                     m_last_row;
    logic                     m_last_ch;
    logic                     m_last;

    modport slave (
        input  fm_valid, fm_data, m_ready,
        output fm_ready, m_valid, m_data, m_ch, m_row, m_col,
               m_last_row, m_last_ch, m_last
    );

    modport master (
        output fm_valid, fm_data, m_ready,
        input  fm_ready, m_valid, m_data, m_ch, m_row, m_col,
               m_last_row, m_last_ch, m_last
    );
endinterface

// File: rtl/conv_fmap_streamer.sv
// Captures one parallel feature map in a single handshake and replays it as a
// channel-major, row, column element stream with position and last markers.
module conv_fmap_streamer #(
    parameter int OUT_DEPTH  = 32,
    parameter int OUT_HEIGHT = 5,
    parameter int OUT_WIDTH  = 5,
    parameter int DATA_W     = 18,
    parameter int FRAC       = 9,
    parameter int RELU_EN    = 0
) (
    input  logic clk,
    input  logic rst_n,
    conv_fmap_streamer_if.slave bus,
    output logic busy,
    output logic dbg_state
);
    localparam int CH_W  = (OUT_DEPTH  > 1) ? $clog2(OUT_DEPTH)  : 1;
    localparam int ROW_W = (OUT_HEIGHT > 1) ? $clog2(OUT_HEIGHT) : 1;
    localparam int COL_W = (OUT_WIDTH  > 1) ? $clog2(OUT_WIDTH)  : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [CH_W-1:0]          ch_q, ch_d;
    logic [ROW_W-1:0]         row_q, row_d;
    logic [COL_W-1:0]         col_q, col_d;
    logic                     capture;
    logic                     at_col_end, at_row_end, at_ch_end;
    logic                     streaming;
    logic signed [DATA_W-1:0] elem;
    logic signed [DATA_W-1:0] snap_q [0:OUT_DEPTH-1][0:OUT_HEIGHT-1][0:OUT_WIDTH-1];

    assign at_col_end = (col_q == COL_W'(OUT_WIDTH - 1));
    assign at_row_end = (row_q == ROW_W'(OUT_HEIGHT - 1));
    assign at_ch_end  = (ch_q  == CH_W'(OUT_DEPTH - 1));
    assign streaming  = (state_q == STREAM);

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        row_d   = row_q;
        col_d   = col_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.fm_valid) begin
                    capture = 1'b1;
                    ch_d    = '0;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (bus.m_ready) begin
                    if (at_col_end) begin
                        col_d = '0;
                        if (at_row_end) begin
                            row_d = '0;
                            // Final beat of the frame: indices wrap for the next capture.
                            if (at_ch_end) begin
                                ch_d    = '0;
                                state_d = IDLE;
                            end else begin
                                ch_d = ch_q + 1'b1;
                            end
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ch_q    <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // The snapshot decouples the frame in flight from later changes on fm_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < OUT_DEPTH; c++) begin
                for (int r = 0; r < OUT_HEIGHT; r++) begin
                    for (int w = 0; w < OUT_WIDTH; w++) begin
                        snap_q[c][r][w] <= '0;
                    end
                end
            end
        end else if (capture) begin
            snap_q <= bus.fm_data;
        end
    end

    assign elem = snap_q[ch_q][row_q][col_q];

    // Outputs are gated by the state so a degenerate map never shows last flags while idle.
    always_comb begin
        bus.fm_ready   = (state_q == IDLE);
        bus.m_valid    = streaming;
        bus.m_ch       = ch_q;
        bus.m_row      = row_q;
        bus.m_col      = col_q;
        bus.m_last_row = streaming && at_col_end;
        bus.m_last_ch  = streaming && at_col_end && at_row_end;
        bus.m_last     = streaming && at_col_end && at_row_end && at_ch_end;
        bus.m_data     = '0;
        if (streaming && !((RELU_EN != 0) && elem[DATA_W-1])) begin
            bus.m_data = elem;
        end
    end

    assign busy      = streaming;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_conv_fmap_streamer.sv
// Directed bench: 2x2x2 maps with and without ReLU, backpressure, back-to-back
// capture, asynchronous abort, a 1x1x1 map and a full 32x5x5 random-ready frame.
module tb_conv_fmap_streamer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    conv_fmap_streamer_if #(.OUT_DEPTH(2),  .OUT_HEIGHT(2), .OUT_WIDTH(2), .DATA_W(18)) ifa ();
    conv_fmap_streamer_if #(.OUT_DEPTH(2),  .OUT_HEIGHT(2), .OUT_WIDTH(2), .DATA_W(18)) ifb ();
    conv_fmap_streamer_if #(.OUT_DEPTH(1),  .OUT_HEIGHT(1), .OUT_WIDTH(1), .DATA_W(18)) ifc ();
    conv_fmap_streamer_if #(.OUT_DEPTH(32), .OUT_HEIGHT(5), .OUT_WIDTH(5), .DATA_W(18)) ifd ();

    logic busy_a, busy_b, busy_c, busy_d;
    logic dbg_a, dbg_b, dbg_c, dbg_d;

    conv_fmap_streamer #(.OUT_DEPTH(2), .OUT_HEIGHT(2), .OUT_WIDTH(2), .DATA_W(18), .FRAC(9), .RELU_EN(0))
        u_a (.clk(clk), .rst_n(rst_n), .bus(ifa), .busy(busy_a), .dbg_state(dbg_a));
    conv_fmap_streamer #(.OUT_DEPTH(2), .OUT_HEIGHT(2), .OUT_WIDTH(2), .DATA_W(18), .FRAC(9), .RELU_EN(1))
        u_b (.clk(clk), .rst_n(rst_n), .bus(ifb), .busy(busy_b), .dbg_state(dbg_b));
    conv_fmap_streamer #(.OUT_DEPTH(1), .OUT_HEIGHT(1), .OUT_WIDTH(1), .DATA_W(18), .FRAC(9), .RELU_EN(0))
        u_c (.clk(clk), .rst_n(rst_n), .bus(ifc), .busy(busy_c), .dbg_state(dbg_c));
    conv_fmap_streamer #(.OUT_DEPTH(32), .OUT_HEIGHT(5), .OUT_WIDTH(5), .DATA_W(18), .FRAC(9), .RELU_EN(0))
        u_d (.clk(clk), .rst_n(rst_n), .bus(ifd), .busy(busy_d), .dbg_state(dbg_d));

    // The ReLU instance sees exactly the same inputs as the plain one.
    assign ifb.fm_valid = ifa.fm_valid;
    assign ifb.m_ready  = ifa.m_ready;
    assign ifb.fm_data  = ifa.fm_data;

    int map_set [0:1][0:7] = '{
        '{768, -256, 1075, 0, 5, 6, 7, 8},
        '{-1, 2, 3, -4, 100, -100, 131071, -131072}
    };

    logic signed [17:0] exp_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load_a(input int set);
        for (int k = 0; k < 8; k++) begin
            ifa.fm_data[k/4][(k/2)%2][k%2] = 18'(map_set[set][k]);
        end
    endtask

    // Walks one 2x2x2 frame, optionally stalling stall_len cycles on beat stall_beat.
    task automatic stream_a(input int set, input int stall_beat, input int stall_len);
        int beat = 0;
        int stall = 0;
        int cycles = 0;
        int e;
        while (beat < 8 && cycles < 64) begin
            ifa.m_ready = (beat == stall_beat && stall < stall_len) ? 1'b0 : 1'b1;
            e = map_set[set][beat];
            check("a_valid", ifa.m_valid, 1);
            check("a_fm_ready_low", ifa.fm_ready, 0);
            check("a_busy", busy_a, 1);
            check("a_data", ifa.m_data, e);
            check("b_relu_data", ifb.m_data, (e < 0) ? 0 : e);
            check("a_ch", ifa.m_ch, beat / 4);
            check("a_row", ifa.m_row, (beat / 2) % 2);
            check("a_col", ifa.m_col, beat % 2);
            check("a_last_row", ifa.m_last_row, (beat % 2) == 1);
            check("a_last_ch", ifa.m_last_ch, (beat % 4) == 3);
            check("a_last", ifa.m_last, beat == 7);
            if (ifa.m_ready) beat++;
            else stall++;
            tick();
            cycles++;
        end
        ifa.m_ready = 1'b1;
        check("a_beats", beat, 8);
        check("a_cycles", cycles, 8 + stall_len);
        check("a_end_valid", ifa.m_valid, 0);
        check("a_end_fm_ready", ifa.fm_ready, 1);
        check("b_end_valid", ifb.m_valid, 0);
    endtask

    initial begin
        int k, cyc, lasts, v;
        logic signed [17:0] e;

        rst_n        = 1'b0;
        ifa.fm_valid = 1'b0;
        ifa.m_ready  = 1'b1;
        ifc.fm_valid = 1'b0;
        ifc.m_ready  = 1'b1;
        ifc.fm_data[0][0][0] = '0;
        ifd.fm_valid = 1'b0;
        ifd.m_ready  = 1'b0;
        load_a(0);
        for (int c = 0; c < 32; c++)
            for (int r = 0; r < 5; r++)
                for (int w = 0; w < 5; w++)
                    ifd.fm_data[c][r][w] = '0;

        tick();
        tick();
        check("rst_fm_ready", ifa.fm_ready, 1);
        check("rst_valid", ifa.m_valid, 0);
        check("rst_data", ifa.m_data, 0);
        check("rst_busy", busy_a, 0);
        check("rst_state", dbg_a, 0);
        check("rst_c_last", ifc.m_last, 0);
        check("rst_c_last_row", ifc.m_last_row, 0);
        rst_n = 1'b1;
        tick();
        check("post_rst_fm_ready", ifa.fm_ready, 1);

        // Plain frame, continuous ready
        load_a(0);
        ifa.fm_valid = 1'b1;
        tick();
        ifa.fm_valid = 1'b0;
        stream_a(0, -1, 0);

        // Backpressure on beat 3 for three cycles
        ifa.fm_valid = 1'b1;
        tick();
        ifa.fm_valid = 1'b0;
        stream_a(0, 2, 3);

        // fm_valid held high: second map enters only in the first idle cycle
        load_a(0);
        ifa.fm_valid = 1'b1;
        tick();
        load_a(1);
        stream_a(0, -1, 0);
        tick();
        ifa.fm_valid = 1'b0;
        load_a(0);
        stream_a(1, -1, 0);

        // Asynchronous reset while beat 5 is presented
        load_a(0);
        ifa.fm_valid = 1'b1;
        tick();
        ifa.fm_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("abort_pre_data", ifa.m_data, 5);
        #2 rst_n = 1'b0;
        #1;
        check("abort_valid", ifa.m_valid, 0);
        check("abort_ch", ifa.m_ch, 0);
        check("abort_row", ifa.m_row, 0);
        check("abort_col", ifa.m_col, 0);
        check("abort_data", ifa.m_data, 0);
        check("abort_fm_ready", ifa.fm_ready, 1);
        #2 rst_n = 1'b1;
        tick();
        check("abort_idle_valid", ifa.m_valid, 0);
        load_a(1);
        ifa.fm_valid = 1'b1;
        tick();
        ifa.fm_valid = 1'b0;
        stream_a(1, -1, 0);

        // Degenerate 1x1x1 map
        ifc.fm_data[0][0][0] = -18'sd77;
        ifc.fm_valid = 1'b1;
        tick();
        ifc.fm_valid = 1'b0;
        ifc.fm_data[0][0][0] = 18'sd99;
        check("c_valid", ifc.m_valid, 1);
        check("c_data", ifc.m_data, -77);
        check("c_last_row", ifc.m_last_row, 1);
        check("c_last_ch", ifc.m_last_ch, 1);
        check("c_last", ifc.m_last, 1);
        check("c_fm_ready_low", ifc.fm_ready, 0);
        tick();
        check("c_end_valid", ifc.m_valid, 0);
        check("c_end_fm_ready", ifc.fm_ready, 1);

        // Full-size frame with random ready
        for (int c = 0; c < 32; c++)
            for (int r = 0; r < 5; r++)
                for (int w = 0; w < 5; w++) begin
                    v = ((c * 97 + r * 29 + w * 13) % 1024) - 512;
                    ifd.fm_data[c][r][w] = 18'(v);
                    exp_q.push_back(18'(v));
                end
        ifd.fm_valid = 1'b1;
        tick();
        ifd.fm_valid = 1'b0;
        k = 0;
        cyc = 0;
        lasts = 0;
        while (k < 800 && cyc < 5000) begin
            ifd.m_ready = 1'($urandom_range(0, 1));
            if (ifd.m_valid && ifd.m_ready) begin
                e = exp_q.pop_front();
                check("d_data", ifd.m_data, e);
                check("d_ch", ifd.m_ch, k / 25);
                check("d_row", ifd.m_row, (k / 5) % 5);
                check("d_col", ifd.m_col, k % 5);
                check("d_last", ifd.m_last, k == 799);
                if (ifd.m_last) lasts++;
                k++;
            end
            tick();
            cyc++;
        end
        ifd.m_ready = 1'b0;
        check("d_beats", k, 800);
        check("d_last_count", lasts, 1);
        check("d_queue_empty", exp_q.size(), 0);
        check("d_end_valid", ifd.m_valid, 0);
        check("d_end_fm_ready", ifd.fm_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_fmap_streamer.md
Name: conv_fmap_streamer

Overview:
- Sits downstream of the combinational Convolutional layer and is the reader of its parallel output_data array.
- Captures one complete OUT_DEPTH x OUT_HEIGHT x OUT_WIDTH fixed-point feature map in a single handshake.
- Replays the map as a serial valid/ready element stream in channel-major, row, column order, with optional ReLU and position/last markers, for the next layer or the host readback path.

Parameters:
- OUT_DEPTH, 32, number of output channels in the captured map
- OUT_HEIGHT, 5, rows per channel
- OUT_WIDTH, 5, columns per row
- DATA_W, 18, signed fixed-point element width
- FRAC, 9, fractional bits; informational only, no arithmetic depends on it
- RELU_EN, 0, when 1 negative elements are emitted as 0

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- fm_valid  in  1  parallel feature map present on fm_data
- fm_ready  out  1  streamer can capture a map
- fm_data  in  signed DATA_W, unpacked [0:OUT_DEPTH-1][0:OUT_HEIGHT-1][0:OUT_WIDTH-1]  map, wired directly from Convolutional output_data
- m_valid  out  1  stream element valid
- m_ready  in  1  downstream accepts element
- m_data  out  signed DATA_W  element value, after ReLU if enabled
- m_ch  out  $clog2(OUT_DEPTH) (min 1)  channel index of m_data
- m_row  out  $clog2(OUT_HEIGHT) (min 1)  row index
- m_col  out  $clog2(OUT_WIDTH) (min 1)  column index
- m_last_row  out  1  m_col == OUT_WIDTH-1
- m_last_ch  out  1  last element of the current channel
- m_last  out  1  last element of the frame
- busy  out  1  state == STREAM

Behaviour:
- Reset, rst_n low, asynchronous: state=IDLE; snapshot, counters, m_data, m_ch, m_row, m_col, m_last* and m_valid cleared to 0.
- fm_ready is combinational (state==IDLE), so it reads 1 during and after reset.
- Reset mid-stream aborts the frame immediately. No partial resume; the next frame starts at element 0.
- State IDLE: fm_ready=1, m_valid=0. On fm_valid&&fm_ready the whole fm_data array is registered into the snapshot, counters (ch,row,col) are set to 0, and state goes to STREAM.
- State STREAM: fm_ready=0 and fm_data is ignored. m_valid=1 starting in the first cycle after capture, so capture-to-first-valid latency is 1 cycle.
- m_data = snapshot[ch][row][col], muxed from registered counters. If RELU_EN and the value is negative, m_data=0; otherwise it passes unmodified with no rounding or saturation.
- Handshake follows stream rules: while m_valid && !m_ready, m_data, all indices and all last flags hold stable. m_valid never drops until the beat is accepted.
- On each m_valid&&m_ready, counters advance in this order:
  - col increments;
  - at OUT_WIDTH-1, col wraps to 0 and row increments;
  - at OUT_HEIGHT-1, row wraps to 0 and ch increments.
- m_last_ch = last_row && row==OUT_HEIGHT-1.
- m_last = m_last_ch && ch==OUT_DEPTH-1.
- On the handshake of the m_last beat: state goes to IDLE, m_valid=0 next cycle, and fm_ready=1 next cycle. fm_ready is never 1 in the same cycle as the last beat.
- Minimum frame period is N+1 cycles, where N = OUT_DEPTH*OUT_HEIGHT*OUT_WIDTH.
- Back-to-back maps: fm_valid held high during STREAM is not captured. Capture occurs in the first IDLE cycle.
- Degenerate 1x1x1 map: a single beat with m_last_row=m_last_ch=m_last=1.
- fm_data changing after capture has no effect on the frame in flight.

Test Plan:
- Config 2x2x2, RELU_EN=0, Q9 map ch0=[[768,-256],[1075,0]], ch1=[[5,6],[7,8]], m_ready=1 -> 8 beats on consecutive cycles starting 1 cycle after capture, in order 768,-256,1075,0,5,6,7,8. m_last_row on beats 2,4,6,8; m_last_ch on beats 4,8; m_last on beat 8 only. fm_ready is 1 again 1 cycle after beat 8.
- Same map, RELU_EN=1 -> beat 2 emits 0, all other beats are unchanged.
- Backpressure: m_ready low for 3 cycles on beat 3 -> m_data=1075, m_ch=0, m_row=1, m_col=0 held for 3 cycles. Total frame takes 11 cycles after capture and no beat is duplicated or dropped.
- fm_valid held high continuously with two different maps -> second map captured exactly 1 cycle after first frame's m_last. fm_data changes during STREAM do not appear in the first frame.
- rst_n pulsed low during beat 5 -> m_valid=0 and indices=0 immediately, asynchronously. After release, fm_ready=1 and a new capture streams from element 0.
- Default 32x5x5 fed from Convolutional with the standard stimulus, m_ready random 50% -> 800 beats whose values match the parallel output_data element-for-element, with exactly one m_last.
